// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle,
// XLEN steps per operation, followed by a sign-fix cycle and a one-cycle
// DONE state that raises o_valid. Divide-by-zero and signed overflow skip
// the iteration and go straight to DONE.
//
// Handshake: a request is accepted when i_start=1 while o_busy=0 (IDLE);
// there is no ready/backpressure on the result side. o_valid pulses for
// exactly one cycle when o_result/o_rd_addr are to be written back.
// i_start is ignored while o_busy=1.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr,
    output logic [1:0]      o_dbg_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
    logic [XLEN-1:0] acc_lo;   // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0] opb;      // multiplicand or divisor magnitude
    logic            op_div;
    logic            op_high;  // MULH* selects the upper product half
    logic            op_rem;   // REM* selects the remainder
    logic            neg_res;
    logic [4:0]      rd_q;

    // Request decode, all from the live inputs at the accept edge.
    logic            is_div, rs1_signed, rs2_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic            div_zero, div_ovf, special;

    // Iteration and sign-fix datapath.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Decode operand signedness, magnitudes and the special cases.
    always_comb begin
        is_div     = i_funct3[2];
        rs1_signed = is_div ? ~i_funct3[0]
                            : (i_funct3[1:0] == 2'b01 || i_funct3[1:0] == 2'b10);
        rs2_signed = is_div ? ~i_funct3[0] : (i_funct3[1:0] == 2'b01);
        a_neg      = rs1_signed & i_rs1_data[XLEN-1];
        b_neg      = rs2_signed & i_rs2_data[XLEN-1];
        a_mag      = a_neg ? (~i_rs1_data + XLEN'(1)) : i_rs1_data;
        b_mag      = b_neg ? (~i_rs2_data + XLEN'(1)) : i_rs2_data;
        div_zero   = is_div && (i_rs2_data == '0);
        div_ovf    = is_div && !i_funct3[0] && (i_rs1_data == MOST_NEG) && (i_rs2_data == '1);
        special    = div_zero | div_ovf;
        if (div_zero)
            special_res = i_funct3[1] ? i_rs1_data : '1;
        else
            special_res = i_funct3[1] ? '0 : i_rs1_data;
    end

    // One multiply or divide step, plus the final sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb};
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_res ? (~prod + (2*XLEN)'(1)) : prod;
        quo_fix   = neg_res ? (~acc_lo + XLEN'(1)) : acc_lo;
        rem_fix   = neg_res ? (~acc_hi + XLEN'(1)) : acc_hi;
        if (op_div)
            fix_res = op_rem ? rem_fix : quo_fix;
        else
            fix_res = op_high ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; flush aborts any non-IDLE state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (i_start) state_next = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (i_flush)                        state_next = S_IDLE;
                else if (cnt == CW'(XLEN-1))        state_next = S_FIX;
            end
            S_FIX:  state_next = i_flush ? S_IDLE : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration and result registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            op_div    <= 1'b0;
            op_high   <= 1'b0;
            op_rem    <= 1'b0;
            neg_res   <= 1'b0;
            rd_q      <= '0;
            o_result  <= '0;
            o_rd_addr <= '0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= (state_next == S_DONE);
            if (state == S_IDLE && i_start) begin
                cnt     <= '0;
                acc_hi  <= '0;
                acc_lo  <= is_div ? a_mag : b_mag;
                opb     <= is_div ? b_mag : a_mag;
                op_div  <= is_div;
                op_high <= (i_funct3[1:0] != 2'b00);
                op_rem  <= i_funct3[1];
                neg_res <= (is_div && i_funct3[1]) ? a_neg : (a_neg ^ b_neg);
                rd_q    <= i_rd_addr;
                if (special) begin
                    o_result  <= special_res;
                    o_rd_addr <= i_rd_addr;
                end
            end else if (state == S_CALC) begin
                cnt <= cnt + CW'(1);
                if (op_div) begin
                    if (!div_diff[XLEN]) begin
                        acc_hi <= div_diff[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end
            end else if (state == S_FIX && !i_flush) begin
                o_result  <= fix_res;
                o_rd_addr <= rd_q;
            end
        end
    end

    assign o_busy      = (state != S_IDLE);
    assign o_dbg_state = state;

endmodule
